test_phase_sequencer: RTL and testbench

//   Hardware sequencer for a self-checking test suite. Steps through the phases

---
 rtl/test_phase_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_test_phase_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_phase_sequencer.sv
// Test-suite phase sequencer: issues suite/case setup, run and cleanup phases to an
// executor over a valid/done handshake, guards runs with a watchdog and tallies results.
module test_phase_sequencer #(
  parameter int NUM_CASES       = 3,
  parameter int WATCHDOG_CYCLES = 1000,
  parameter int WD_W            = 32,
  parameter bit STOP_ON_FAIL    = 1'b0,
  localparam int IW = (NUM_CASES > 1) ? $clog2(NUM_CASES) : 1,
  localparam int CW = IW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CASES-1:0] case_enable,
  output logic                 phase_valid,
  output logic [2:0]           phase_code,
  output logic [IW-1:0]        case_idx,
  input  logic                 phase_done,
  input  logic                 phase_fail,
  output logic                 result_valid,
  output logic [IW-1:0]        result_idx,
  output logic                 result_pass,
  output logic                 result_timeout,
  output logic [CW-1:0]        pass_count,
  output logic [CW-1:0]        fail_count,
  output logic                 suite_fail,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] PH_SSETUP = 3'd0;
  localparam logic [2:0] PH_CSETUP = 3'd1;
  localparam logic [2:0] PH_CRUN   = 3'd2;
  localparam logic [2:0] PH_CCLEAN = 3'd3;
  localparam logic [2:0] PH_SCLEAN = 3'd4;

  localparam bit              WD_EN    = (WATCHDOG_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_SSETUP, S_CSETUP, S_CRUN, S_CCLEAN, S_SCLEAN, S_DONE
  } state_t;

  state_t                 state_r;
  logic [NUM_CASES-1:0]   mask_r;
  logic [WD_W-1:0]        wd_cnt_r;
  logic                   case_fail_r;
  logic                   case_timeout_r;

  logic                   hs_s;
  logic                   next_found_s;
  logic [IW-1:0]          next_idx_s;
  logic                   final_fail_s;

  assign hs_s         = phase_valid & phase_done;
  assign final_fail_s = case_fail_r | phase_fail;

  // Lowest enabled case above the current one (from index 0 while in suite setup).
  always_comb begin
    next_found_s = 1'b0;
    next_idx_s   = '0;
    for (int i = NUM_CASES - 1; i >= 0; i--) begin
      if (mask_r[i] && ((state_r == S_SSETUP) || (i > int'(case_idx)))) begin
        next_found_s = 1'b1;
        next_idx_s   = IW'(i);
      end else begin
        next_found_s = next_found_s;
        next_idx_s   = next_idx_s;
      end
    end
  end

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      mask_r         <= '0;
      wd_cnt_r       <= '0;
      case_fail_r    <= 1'b0;
      case_timeout_r <= 1'b0;
      phase_valid    <= 1'b0;
      phase_code     <= 3'd0;
      case_idx       <= '0;
      result_valid   <= 1'b0;
      result_idx     <= '0;
      result_pass    <= 1'b0;
      result_timeout <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      suite_fail     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            mask_r      <= case_enable;
            pass_count  <= '0;
            fail_count  <= '0;
            suite_fail  <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            phase_valid <= 1'b1;
            phase_code  <= PH_SSETUP;
            case_idx    <= '0;
            state_r     <= S_SSETUP;
          end
        end
        S_SSETUP: begin
          if (hs_s) begin
            if (!phase_fail && next_found_s) begin
              case_fail_r    <= 1'b0;
              case_timeout_r <= 1'b0;
              phase_code     <= PH_CSETUP;
              case_idx       <= next_idx_s;
              state_r        <= S_CSETUP;
            end else begin
              suite_fail <= suite_fail | phase_fail;
              phase_code <= PH_SCLEAN;
              case_idx   <= '0;
              state_r    <= S_SCLEAN;
            end
          end
        end
        S_CSETUP: begin
          if (hs_s) begin
            case_fail_r <= phase_fail;
            wd_cnt_r    <= '0;
            phase_code  <= phase_fail ? PH_CCLEAN : PH_CRUN;
            state_r     <= phase_fail ? S_CCLEAN : S_CRUN;
          end
        end
        S_CRUN: begin
          // A done arriving in the timeout cycle takes priority over the watchdog.
          if (hs_s) begin
            case_fail_r <= final_fail_s;
            phase_code  <= PH_CCLEAN;
            state_r     <= S_CCLEAN;
          end else if (WD_EN && (wd_cnt_r == WD_LIMIT)) begin
            case_fail_r    <= 1'b1;
            case_timeout_r <= 1'b1;
            phase_code     <= PH_CCLEAN;
            state_r        <= S_CCLEAN;
          end else begin
            wd_cnt_r <= WD_EN ? (wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1}) : wd_cnt_r;
          end
        end
        S_CCLEAN: begin
          if (hs_s) begin
            result_valid   <= 1'b1;
            result_idx     <= case_idx;
            result_pass    <= ~final_fail_s;
            result_timeout <= case_timeout_r;
            if (final_fail_s) begin
              fail_count <= (fail_count == CNT_MAX) ? fail_count : (fail_count + {{(CW-1){1'b0}}, 1'b1});
            end else begin
              pass_count <= (pass_count == CNT_MAX) ? pass_count : (pass_count + {{(CW-1){1'b0}}, 1'b1});
            end
            if ((STOP_ON_FAIL && final_fail_s) || !next_found_s) begin
              phase_code <= PH_SCLEAN;
              case_idx   <= '0;
              state_r    <= S_SCLEAN;
            end else begin
              case_fail_r    <= 1'b0;
              case_timeout_r <= 1'b0;
              phase_code     <= PH_CSETUP;
              case_idx       <= next_idx_s;
              state_r        <= S_CSETUP;
            end
          end
        end
        S_SCLEAN: begin
          if (hs_s) begin
            suite_fail  <= suite_fail | phase_fail;
            phase_valid <= 1'b0;
            phase_code  <= 3'd0;
            case_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= S_DONE;
          end
        end
        default: begin
          phase_valid <= 1'b0;
          phase_code  <= 3'd0;
          case_idx    <= '0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_phase_sequencer.sv
// Directed bench for test_phase_sequencer: one instance with a 10-cycle watchdog and
// one with stop-on-fail enabled, driven by a linear sequence of executor steps.
module tb_test_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [2:0] case_enable = 3'b000;
  logic       phase_done = 1'b0, phase_fail = 1'b0;
  logic       sel = 1'b0;

  logic       a_phase_valid, a_result_valid, a_result_pass, a_result_timeout, a_suite_fail, a_busy, a_done;
  logic [2:0] a_phase_code, a_pass_count, a_fail_count;
  logic [1:0] a_case_idx, a_result_idx;
  logic       b_phase_valid, b_result_valid, b_result_pass, b_result_timeout, b_suite_fail, b_busy, b_done;
  logic [2:0] b_phase_code, b_pass_count, b_fail_count;
  logic [1:0] b_case_idx, b_result_idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  test_phase_sequencer #(.NUM_CASES(3), .WATCHDOG_CYCLES(10), .WD_W(32), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start_a), .case_enable(case_enable),
    .phase_valid(a_phase_valid), .phase_code(a_phase_code), .case_idx(a_case_idx),
    .phase_done(phase_done), .phase_fail(phase_fail),
    .result_valid(a_result_valid), .result_idx(a_result_idx), .result_pass(a_result_pass),
    .result_timeout(a_result_timeout), .pass_count(a_pass_count), .fail_count(a_fail_count),
    .suite_fail(a_suite_fail), .busy(a_busy), .done(a_done));

  test_phase_sequencer #(.NUM_CASES(3), .WATCHDOG_CYCLES(10), .WD_W(32), .STOP_ON_FAIL(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start_b), .case_enable(case_enable),
    .phase_valid(b_phase_valid), .phase_code(b_phase_code), .case_idx(b_case_idx),
    .phase_done(phase_done), .phase_fail(phase_fail),
    .result_valid(b_result_valid), .result_idx(b_result_idx), .result_pass(b_result_pass),
    .result_timeout(b_result_timeout), .pass_count(b_pass_count), .fail_count(b_fail_count),
    .suite_fail(b_suite_fail), .busy(b_busy), .done(b_done));

  logic       o_valid, o_rvalid, o_rpass, o_rtmo, o_sfail, o_busy, o_done;
  logic [2:0] o_code, o_pass, o_fail;
  logic [1:0] o_idx, o_ridx;
  assign o_valid  = sel ? b_phase_valid    : a_phase_valid;
  assign o_code   = sel ? b_phase_code     : a_phase_code;
  assign o_idx    = sel ? b_case_idx       : a_case_idx;
  assign o_rvalid = sel ? b_result_valid   : a_result_valid;
  assign o_ridx   = sel ? b_result_idx     : a_result_idx;
  assign o_rpass  = sel ? b_result_pass    : a_result_pass;
  assign o_rtmo   = sel ? b_result_timeout : a_result_timeout;
  assign o_pass   = sel ? b_pass_count     : a_pass_count;
  assign o_fail   = sel ? b_fail_count     : a_fail_count;
  assign o_sfail  = sel ? b_suite_fail     : a_suite_fail;
  assign o_busy   = sel ? b_busy           : a_busy;
  assign o_done   = sel ? b_done           : a_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the presented phase, let the executor take 'delay' extra cycles, then complete it.
  task automatic phase(input string tag, input logic [2:0] code, input logic [1:0] idx,
                       input int delay, input logic fail);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_code"}, {29'd0, o_code}, {29'd0, code});
    chk({tag, "_idx"}, {30'd0, o_idx}, {30'd0, idx});
    repeat (delay) @(negedge clk);
    phase_done = 1'b1;
    phase_fail = fail;
    @(negedge clk);
    phase_done = 1'b0;
    phase_fail = 1'b0;
  endtask

  task automatic result(input string tag, input logic [1:0] idx, input logic pass, input logic tmo);
    chk({tag, "_rvalid"}, {31'd0, o_rvalid}, 32'd1);
    chk({tag, "_ridx"}, {30'd0, o_ridx}, {30'd0, idx});
    chk({tag, "_rpass"}, {31'd0, o_rpass}, {31'd0, pass});
    chk({tag, "_rtmo"}, {31'd0, o_rtmo}, {31'd0, tmo});
  endtask

  task automatic begin_suite(input string tag, input logic b, input logic [2:0] m);
    sel = b;
    case_enable = m;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
    chk({tag, "_done0"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_cnt0"}, {26'd0, o_pass, o_fail}, 32'd0);
  endtask

  task automatic end_suite(input string tag, input logic [2:0] p, input logic [2:0] f, input logic sf);
    chk({tag, "_done"}, {29'd0, o_done, o_busy, o_valid}, 32'd4);
    chk({tag, "_pass"}, {29'd0, o_pass}, {29'd0, p});
    chk({tag, "_fail"}, {29'd0, o_fail}, {29'd0, f});
    chk({tag, "_sfail"}, {31'd0, o_sfail}, {31'd0, sf});
  endtask

  function automatic logic [31:0] a_outs();
    return {12'd0, a_phase_valid, a_phase_code, a_case_idx, a_result_valid, a_result_idx,
            a_result_pass, a_result_timeout, a_pass_count, a_fail_count, a_suite_fail, a_busy, a_done};
  endfunction

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    chk("reset_outs", a_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", a_outs(), 32'd0);

    // All three cases enabled, every phase done on its second cycle.
    begin_suite("t1", 1'b0, 3'b111);
    phase("t1_ss", 3'd0, 2'd0, 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      phase("t1_cs", 3'd1, 2'(c), 1, 1'b0);
      phase("t1_cr", 3'd2, 2'(c), 1, 1'b0);
      phase("t1_cc", 3'd3, 2'(c), 1, 1'b0);
      result("t1_res", 2'(c), 1'b1, 1'b0);
    end
    phase("t1_sc", 3'd4, 2'd0, 1, 1'b0);
    end_suite("t1", 3'd3, 3'd0, 1'b0);
    chk("t1_rvalid_idle", {31'd0, o_rvalid}, 32'd0);
    phase_done = 1'b1;
    @(negedge clk);
    phase_done = 1'b0;
    chk("t1_done_ignored", {29'd0, o_done, o_busy, o_valid}, 32'd4);

    // Case 1 disabled; a start while busy must not disturb the suite.
    begin_suite("t2", 1'b0, 3'b101);
    phase("t2_ss", 3'd0, 2'd0, 0, 1'b0);
    phase("t2_cs0", 3'd1, 2'd0, 0, 1'b0);
    case_enable = 3'b111;
    start_a = 1'b1;
    phase("t2_cr0", 3'd2, 2'd0, 0, 1'b0);
    start_a = 1'b0;
    phase("t2_cc0", 3'd3, 2'd0, 0, 1'b0);
    phase("t2_cs2", 3'd1, 2'd2, 0, 1'b0);
    phase("t2_cr2", 3'd2, 2'd2, 0, 1'b0);
    phase("t2_cc2", 3'd3, 2'd2, 0, 1'b0);
    result("t2_res2", 2'd2, 1'b1, 1'b0);
    phase("t2_sc", 3'd4, 2'd0, 0, 1'b0);
    end_suite("t2", 3'd2, 3'd0, 1'b0);

    // Watchdog expiry on case 1's run.
    begin_suite("t3", 1'b0, 3'b010);
    phase("t3_ss", 3'd0, 2'd0, 0, 1'b0);
    phase("t3_cs1", 3'd1, 2'd1, 0, 1'b0);
    chk("t3_crun", {29'd0, o_code}, 32'd2);
    cnt = 0;
    while (o_valid && (o_code == 3'd2) && (cnt < 40)) begin
      @(negedge clk);
      cnt++;
    end
    chk("t3_wd_cycles", cnt, 32'd10);
    phase("t3_cc1", 3'd3, 2'd1, 0, 1'b0);
    result("t3_res1", 2'd1, 1'b0, 1'b1);
    phase("t3_sc", 3'd4, 2'd0, 0, 1'b0);
    end_suite("t3", 3'd0, 3'd1, 1'b0);

    // Done arriving in the very cycle the watchdog would fire wins.
    begin_suite("t3b", 1'b0, 3'b001);
    phase("t3b_ss", 3'd0, 2'd0, 0, 1'b0);
    phase("t3b_cs", 3'd1, 2'd0, 0, 1'b0);
    phase("t3b_cr", 3'd2, 2'd0, 9, 1'b0);
    phase("t3b_cc", 3'd3, 2'd0, 0, 1'b0);
    result("t3b_res", 2'd0, 1'b1, 1'b0);
    phase("t3b_sc", 3'd4, 2'd0, 0, 1'b0);
    end_suite("t3b", 3'd1, 3'd0, 1'b0);

    // Case setup failure skips the run phase.
    begin_suite("t4", 1'b0, 3'b001);
    phase("t4_ss", 3'd0, 2'd0, 0, 1'b0);
    phase("t4_cs", 3'd1, 2'd0, 0, 1'b1);
    phase("t4_cc", 3'd3, 2'd0, 0, 1'b0);
    result("t4_res", 2'd0, 1'b0, 1'b0);
    phase("t4_sc", 3'd4, 2'd0, 0, 1'b0);
    end_suite("t4", 3'd0, 3'd1, 1'b0);

    // Suite setup failure skips every case.
    begin_suite("t4s", 1'b0, 3'b111);
    phase("t4s_ss", 3'd0, 2'd0, 0, 1'b1);
    phase("t4s_sc", 3'd4, 2'd0, 0, 1'b0);
    end_suite("t4s", 3'd0, 3'd0, 1'b1);

    // Stop-on-fail instance: failing case 0 run ends the suite early.
    begin_suite("t5", 1'b1, 3'b011);
    phase("t5_ss", 3'd0, 2'd0, 0, 1'b0);
    phase("t5_cs", 3'd1, 2'd0, 0, 1'b0);
    phase("t5_cr", 3'd2, 2'd0, 1, 1'b1);
    phase("t5_cc", 3'd3, 2'd0, 0, 1'b0);
    result("t5_res", 2'd0, 1'b0, 1'b0);
    phase("t5_sc", 3'd4, 2'd0, 0, 1'b0);
    end_suite("t5", 3'd0, 3'd1, 1'b0);

    // Asynchronous reset in the middle of a run, then a fresh suite.
    begin_suite("t6a", 1'b0, 3'b111);
    phase("t6a_ss", 3'd0, 2'd0, 0, 1'b0);
    phase("t6a_cs", 3'd1, 2'd0, 0, 1'b0);
    #2 rst = 1'b1;
    #1 chk("t6_async_rst", a_outs(), 32'd0);
    @(negedge clk);
    chk("t6_in_rst", a_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after_rst", a_outs(), 32'd0);
    begin_suite("t6", 1'b0, 3'b001);
    phase("t6_ss", 3'd0, 2'd0, 0, 1'b0);
    phase("t6_cs", 3'd1, 2'd0, 0, 1'b0);
    phase("t6_cr", 3'd2, 2'd0, 0, 1'b0);
    phase("t6_cc", 3'd3, 2'd0, 0, 1'b0);
    result("t6_res", 2'd0, 1'b1, 1'b0);
    phase("t6_sc", 3'd4, 2'd0, 0, 1'b0);
    end_suite("t6", 3'd1, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
